segment_reader: RTL
===================

SEGMENT_READER -- requirements
Module: segment_reader

Interface
REQ-001 Parameter STABLE_TICKS, default 3: consecutive sample ticks a pattern must hold before it is accepted; legal range 1-15.
REQ-002 Parameter FIFO_DEPTH, default 4: decoded-character buffer depth; power of two, 2-8.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 ena  input  1  block enable; low freezes sampling.
REQ-006 tick  input  1  one-clk-wide sample strobe from the clock divider's 60 Hz output.
REQ-007 seg_in  input  7  external segment pattern, active high; bit0=a through bit6=g; asynchronous to clk.
REQ-008 char_ready  input  1  consumer accepts char_out this cycle.
REQ-009 err_clr  input  1  clears err_flag.
REQ-010 char_valid  output  1  FIFO non-empty; char_out is meaningful.
REQ-011 char_out  output  4  hex value at FIFO head.
REQ-012 fifo_count  output  4  current FIFO occupancy, 0 to FIFO_DEPTH.
REQ-013 err_flag  output  1  sticky: a stable non-hex, non-blank pattern was seen.
REQ-014 overflow  output  1  sticky: a decoded character was dropped because the FIFO was full.

Function
REQ-015 seg_in SHALL pass through a 2-flop synchronizer; all logic uses only the synchronized value (seg_s).
REQ-016 Stability FSM states: SETTLE and STABLE; registers: cand[6:0], cnt[3:0], last[6:0].
REQ-017 On a tick with ena=1 and seg_s != cand: cand<=seg_s, cnt<=1, state<=SETTLE.
REQ-018 On a tick with ena=1, seg_s==cand, state SETTLE: cnt increments; when cnt+1==STABLE_TICKS, state<=STABLE and one commit event fires in that cycle.
REQ-019 If STABLE_TICKS==1, the commit fires on the same tick that loads cand.
REQ-020 Tick with ena=1 in STABLE with seg_s==cand: no change, no commit.
REQ-021 Commit with cand==last: no push, no error (glitch that returned to the previous pattern).
REQ-022 Commit with cand!=last: last<=cand; then:
- cand==7'h00 (blank): no push.
- cand in the decode table (REQ-023): push its nibble.
- otherwise: set err_flag, no push.
REQ-023 Decode table: 3F=0, 06=1, 5B=2, 4F=3, 66=4, 6D=5, 7D=6, 07=7, 7F=8, 6F=9, 77=A, 7C=b, 39=C, 5E=d, 79=E, 71=F.
REQ-024 Commit-to-char_valid latency: push written on the commit clock edge; char_valid high the following cycle.
REQ-025 Total latency, seg_in change to char_valid: 2 sync cycles plus STABLE_TICKS ticks plus 1 cycle.
REQ-026 FIFO handshake: pop occurs when char_valid && char_ready; char_out SHALL remain stable until popped.
REQ-027 Push with FIFO full and no pop: character dropped; overflow set.
REQ-028 Push and pop in the same cycle when full: both occur; count unchanged; no overflow.
REQ-029 Push and pop in the same cycle when empty: FIFO empty is not bypassed; push lands; count becomes 1.
REQ-030 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-031 ena=0: ticks ignored (FSM and cnt frozen); FIFO pops and err_clr still operate.
REQ-032 err_clr has priority over a same-cycle error set: err_flag=0. overflow clears only on reset.

Reset
REQ-033 rst_n low asynchronously forces:
- state=STABLE, cand=00, last=00, cnt=STABLE_TICKS
- FIFO empty, sync flops 00
- char_valid=0, char_out=0, fifo_count=0, err_flag=0, overflow=0
REQ-034 Reset asserted mid-settle or with a non-empty FIFO SHALL discard all pending data; the first post-reset commit compares against last=00.

Verification
REQ-035 seg_in=3F held 3 ticks, char_ready=0 -> char_valid=1, char_out=0, fifo_count=1 one cycle after the third tick.
REQ-036 seg_in 3F for 1 tick, then 06 for 3 ticks -> exactly one push, char_out=1; no push for 3F.
REQ-037 Stable 3F accepted, glitch to 06 for 1 tick, back to 3F for 3 ticks -> no further push, err_flag=0.
REQ-038 Sequence 06,00,06,00,06,00,06,00,06 (each 3 ticks), char_ready=0 -> fifo_count=4, overflow=1 after the fifth 06; then pop all -> outputs 1,1,1,1.
REQ-039 seg_in=7E stable 3 ticks -> err_flag=1, no push; err_clr pulse -> err_flag=0.
REQ-040 FIFO full with char_ready=1 on the same cycle as a commit of 5B -> count stays 4, overflow=0, 2 at tail. Then rst_n pulse mid-settle -> all outputs 0.

Source files
------------

// File: rtl/segment_reader.sv
// segment_reader: samples an asynchronous 7-segment pattern, waits until the pattern
// has been steady for STABLE_TICKS sample ticks, then decodes it to a hex nibble and
// queues it in a small FIFO.
//
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   ena          - enable; low freezes tick sampling (FIFO and err_clr still work)
//   tick         - one-cycle sample strobe
//   seg_in[6:0]  - raw segment pattern, bit0=a .. bit6=g, asynchronous to clk
//   char_ready   - consumer accepts char_out this cycle
//   err_clr      - clears err_flag (wins over a same-cycle error)
//   char_valid   - FIFO non-empty
//   char_out     - hex nibble at FIFO head (0 when empty)
//   fifo_count   - FIFO occupancy
//   err_flag     - sticky: stable non-hex, non-blank pattern seen
//   overflow     - sticky: a character was dropped on a full FIFO
module segment_reader #(
  parameter int unsigned STABLE_TICKS = 3,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       tick,
  input  logic [6:0] seg_in,
  input  logic       char_ready,
  input  logic       err_clr,
  output logic       char_valid,
  output logic [3:0] char_out,
  output logic [3:0] fifo_count,
  output logic       err_flag,
  output logic       overflow
);

  localparam int unsigned PtrW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [3:0]  StableCnt = 4'(STABLE_TICKS);
  localparam logic [3:0]  DepthCnt  = 4'(FIFO_DEPTH);

  typedef enum logic {StSettle, StStable} state_e;

  // Returns {hit, nibble}; hit=0 for patterns outside the hex table.
  function automatic logic [4:0] decode(input logic [6:0] pat);
    case (pat)
      7'h3F: decode = 5'h10;
      7'h06: decode = 5'h11;
      7'h5B: decode = 5'h12;
      7'h4F: decode = 5'h13;
      7'h66: decode = 5'h14;
      7'h6D: decode = 5'h15;
      7'h7D: decode = 5'h16;
      7'h07: decode = 5'h17;
      7'h7F: decode = 5'h18;
      7'h6F: decode = 5'h19;
      7'h77: decode = 5'h1A;
      7'h7C: decode = 5'h1B;
      7'h39: decode = 5'h1C;
      7'h5E: decode = 5'h1D;
      7'h79: decode = 5'h1E;
      7'h71: decode = 5'h1F;
      default: decode = 5'h00;
    endcase
  endfunction

  logic [6:0]     seg_meta_q, seg_s_q;
  state_e         state_q, state_d;
  logic [6:0]     cand_q, cand_d, last_q, last_d;
  logic [3:0]     cnt_q, cnt_d;
  logic           commit, push, err_set;
  logic [4:0]     dec;
  logic           err_q, err_d, ovf_q, ovf_d;
  logic [3:0]     mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [3:0]     fcnt_q, fcnt_d;
  logic           full, empty, pop, wr_en, ovf_set;

  // Stability tracking and commit decode.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    commit  = 1'b0;
    push    = 1'b0;
    err_set = 1'b0;
    dec     = decode(seg_s_q);
    if (tick && ena) begin
      if (seg_s_q != cand_q) begin
        cand_d = seg_s_q;
        cnt_d  = 4'd1;
        if (StableCnt == 4'd1) begin
          state_d = StStable;
          commit  = 1'b1;
        end else begin
          state_d = StSettle;
        end
      end else if (state_q == StSettle) begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q + 4'd1 == StableCnt) begin
          state_d = StStable;
          commit  = 1'b1;
        end
      end
    end
    // On a commit seg_s_q always equals the (new) candidate.
    if (commit && (seg_s_q != last_q)) begin
      last_d = seg_s_q;
      if (seg_s_q == 7'h00) begin
        push = 1'b0;
      end else if (dec[4]) begin
        push = 1'b1;
      end else begin
        err_set = 1'b1;
      end
    end
  end

  // FIFO control: a full FIFO still accepts a push when a pop frees a slot.
  always_comb begin
    full    = (fcnt_q == DepthCnt);
    empty   = (fcnt_q == 4'd0);
    pop     = !empty && char_ready;
    wr_en   = push && (!full || pop);
    ovf_set = push && full && !pop;
    wptr_d  = wr_en ? wptr_q + PtrW'(1) : wptr_q;
    rptr_d  = pop ? rptr_q + PtrW'(1) : rptr_q;
    fcnt_d  = fcnt_q;
    if (wr_en && !pop) begin
      fcnt_d = fcnt_q + 4'd1;
    end else if (pop && !wr_en) begin
      fcnt_d = fcnt_q - 4'd1;
    end
    err_d = err_clr ? 1'b0 : (err_set ? 1'b1 : err_q);
    ovf_d = ovf_q | ovf_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_meta_q <= 7'h00;
      seg_s_q    <= 7'h00;
      state_q    <= StStable;
      cand_q     <= 7'h00;
      last_q     <= 7'h00;
      cnt_q      <= StableCnt;
      wptr_q     <= '0;
      rptr_q     <= '0;
      fcnt_q     <= 4'd0;
      err_q      <= 1'b0;
      ovf_q      <= 1'b0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 4'h0;
      end
    end else begin
      seg_meta_q <= seg_in;
      seg_s_q    <= seg_meta_q;
      state_q    <= state_d;
      cand_q     <= cand_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      fcnt_q     <= fcnt_d;
      err_q      <= err_d;
      ovf_q      <= ovf_d;
      if (wr_en) begin
        mem_q[wptr_q] <= dec[3:0];
      end
    end
  end

  assign char_valid = !empty;
  assign char_out   = empty ? 4'h0 : mem_q[rptr_q];
  assign fifo_count = fcnt_q;
  assign err_flag   = err_q;
  assign overflow   = ovf_q;

endmodule
